// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters; operands held 1 or MULTI_CYC cycles.
// Transfer at T -> response pulse at T+1+cnt; ready only in IDLE for the granted requester, no response backpressure.
module alu_share_ctrl #(
  parameter int N         = 8,
  parameter int MULTI_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_ctrl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_ctrl,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         busy
);

  localparam int CW = (MULTI_CYC < 2) ? 1 : $clog2(MULTI_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MULTI = CW'(MULTI_CYC);

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          divz_q, divz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  alu_a_q, alu_a_d;
  logic [N-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [N-1:0]  rsp_result_q, rsp_result_d;
  logic [3:0]    rsp_flags_q, rsp_flags_d;

  logic          grant0, grant1, xfer;
  logic [N-1:0]  sel_a, sel_b;
  logic [3:0]    sel_ctrl;
  logic          sel_multi, sel_divz;

  // Ties go to the requester that was not served last; ready is masked in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == S_IDLE) && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign xfer     = grant0 | grant1;
  assign sel_a    = grant1 ? req1_a    : req0_a;
  assign sel_b    = grant1 ? req1_b    : req0_b;
  assign sel_ctrl = grant1 ? req1_ctrl : req0_ctrl;

  assign sel_multi = (sel_ctrl == OP_MUL) || (sel_ctrl == OP_MOD) || (sel_ctrl == OP_DIV);
  assign sel_divz  = ((sel_ctrl == OP_MOD) || (sel_ctrl == OP_DIV)) && (sel_b == '0);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    divz_d       = divz_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          alu_ctrl_d   = sel_ctrl;
          owner_d      = grant1;
          last_grant_d = grant1;
          divz_d       = sel_divz;
          cnt_d        = (sel_multi && !sel_divz) ? CNT_MULTI : CNT_ONE;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_ONE) begin
          // A zero divisor never reaches a valid ALU result, so substitute the saturated answer.
          rsp_result_d = divz_q ? {N{1'b1}} : alu_result;
          rsp_flags_d  = divz_q ? 4'b0001   : alu_flags;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      divz_q       <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      divz_q       <= divz_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid = (state_q == S_RESP) && owner_q;
  assign busy       = (state_q == S_EXEC) || (state_q == S_RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: reference ALU on the alu_* port, vector table plus arbitration,
// hold-stability and reset-abort sequences, with a scoreboard of expected responses.
module tb_alu_share_ctrl;
  localparam int N  = 8;
  localparam int MC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic         rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]   rsp_flags, alu_ctrl, alu_flags;
  logic         busy;

  alu_share_ctrl #(.N(N), .MULTI_CYC(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] ctrl;
    logic [7:0] res;
    logic [3:0] flg;
    int         cnt;
  } vec_t;

  typedef struct {
    int         port;
    logic [7:0] res;
    logic [3:0] flg;
    int         due;
    int         cnt;
  } sb_t;

  int   n_chk, n_fail, cyc;
  sb_t  sb_q[$];
  int   grant_log[$];
  int   grant_cyc[$];
  vec_t cur[2];
  sb_t  mon_e;
  int   busy_run, busy_exp;

  // Reference ALU; returns 8'hA5 on a zero divisor so that the controller must override it.
  logic [8:0]  m_w;
  logic [15:0] m_p;
  always_comb begin
    m_w        = 9'd0;
    m_p        = 16'd0;
    alu_result = 8'h00;
    alu_flags  = 4'b0000;
    case (alu_ctrl)
      4'b0000: begin
        m_w = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = m_w[7:0];
        alu_flags[1] = m_w[8];
        alu_flags[0] = (alu_a[7] == alu_b[7]) && (m_w[7] != alu_a[7]);
      end
      4'b0001: begin
        m_w = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = m_w[7:0];
        alu_flags[1] = m_w[8];
        alu_flags[0] = (alu_a[7] != alu_b[7]) && (m_w[7] != alu_a[7]);
      end
      4'b0010: begin
        m_p = {8'h00, alu_a} * {8'h00, alu_b};
        alu_result   = m_p[7:0];
        alu_flags[1] = |m_p[15:8];
      end
      4'b0100: alu_result = (alu_b == 8'h00) ? 8'hA5 : (alu_a % alu_b);
      4'b1000: alu_result = (alu_b == 8'h00) ? 8'hA5 : (alu_a / alu_b);
      4'b0101: alu_result = alu_a & alu_b;
      4'b0110: alu_result = alu_a | alu_b;
      4'b0111: alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_flags[3] = alu_result[7];
    alu_flags[2] = (alu_result == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on transfer, pop and compare on each response pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      busy_run = 0;
    end else begin
      if (req0_valid && req0_ready) begin
        sb_q.push_back('{0, cur[0].res, cur[0].flg, cyc + 1 + cur[0].cnt, cur[0].cnt});
        grant_log.push_back(0);
        grant_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back('{1, cur[1].res, cur[1].flg, cyc + 1 + cur[1].cnt, cur[1].cnt});
        grant_log.push_back(1);
        grant_cyc.push_back(cyc);
      end
      if (rsp0_valid || rsp1_valid) begin
        check("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 0);
        if (sb_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_port", 32'(rsp1_valid), mon_e.port);
          check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
          check("rsp_flags", 32'(rsp_flags), 32'(mon_e.flg));
          check("rsp_latency", cyc, mon_e.due);
          busy_exp = mon_e.cnt + 1;
        end
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        check("busy_cycles", busy_run, busy_exp);
        busy_run = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input vec_t v, output int t_acc, output int waited);
    cur[v.port] = v;
    if (v.port == 0) begin
      req0_a = v.a; req0_b = v.b; req0_ctrl = v.ctrl; req0_valid = 1'b1;
    end else begin
      req1_a = v.a; req1_b = v.b; req1_ctrl = v.ctrl; req1_valid = 1'b1;
    end
    waited = 0;
    t_acc  = -1;
    while (t_acc < 0 && waited < 60) begin
      @(negedge clk);
      waited++;
      if ((v.port == 0) ? req0_ready : req1_ready) t_acc = cyc;
    end
    if (t_acc < 0) fail("accept_timeout");
    @(posedge clk);
    #1;
    if (v.port == 0) req0_valid = 1'b0;
    else             req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) fail("drain_timeout");
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    int t0, w0, t1, w1, ta, wa;
    tbl[0]  = '{0, 8'd5,   8'd3,   4'b0000, 8'd8,   4'b0000, 1};
    tbl[1]  = '{1, 8'd3,   8'd3,   4'b0001, 8'd0,   4'b0100, 1};
    tbl[2]  = '{1, 8'd20,  8'd6,   4'b1000, 8'd3,   4'b0000, MC};
    tbl[3]  = '{0, 8'd9,   8'd0,   4'b0100, 8'hFF,  4'b0001, 1};
    tbl[4]  = '{0, 8'd9,   8'd0,   4'b1000, 8'hFF,  4'b0001, 1};
    tbl[5]  = '{1, 8'd16,  8'd0,   4'b0010, 8'd0,   4'b0100, MC};
    tbl[6]  = '{0, 8'd12,  8'd10,  4'b0010, 8'd120, 4'b0000, MC};
    tbl[7]  = '{0, 8'd100, 8'd50,  4'b0000, 8'h96,  4'b1001, 1};
    tbl[8]  = '{1, 8'd17,  8'd5,   4'b0100, 8'd2,   4'b0000, MC};
    tbl[9]  = '{0, 8'hAB,  8'h0F,  4'b1111, 8'd0,   4'b0100, 1};
    tbl[10] = '{1, 8'd2,   8'd5,   4'b0001, 8'hFD,  4'b1010, 1};
    tbl[11] = '{0, 8'd4,   8'd4,   4'b0101, 8'd4,   4'b0000, 1};
    tbl[12] = '{1, 8'd200, 8'd100, 4'b0000, 8'h2C,  4'b0010, 1};

    n_chk = 0; n_fail = 0; cyc = 0; busy_run = 0; busy_exp = 0;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd2; req0_ctrl = 4'b0001;
    req1_valid = 1'b1; req1_a = 8'd4; req1_b = 8'd4; req1_ctrl = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    check("reset_alu_a", 32'(alu_a), 0);
    check("reset_alu_b", 32'(alu_b), 0);
    check("reset_alu_ctrl", 32'(alu_ctrl), 0);
    check("reset_rsp", 32'({rsp_result, rsp_flags}), 0);
    check("reset_ready", 32'({req0_ready, req1_ready}), 0);
    check("reset_rsp_valid_busy", 32'({rsp0_valid, rsp1_valid, busy}), 0);
    rst_n = 1'b1;

    // Both requesters valid out of reset, each re-presenting after being served.
    fork
      begin
        send('{0, 8'd7, 8'd2, 4'b0001, 8'd5, 4'b0000, 1}, t0, w0);
        check("tie_first_wait", w0, 1);
        send('{0, 8'd1, 8'd1, 4'b0000, 8'd2, 4'b0000, 1}, t0, w0);
      end
      begin
        send('{1, 8'd4, 8'd4, 4'b0101, 8'd4, 4'b0000, 1}, t1, w1);
        send('{1, 8'd6, 8'd1, 4'b0001, 8'd5, 4'b0000, 1}, t1, w1);
      end
    join
    drain();
    check("tie_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("tie_order_0", grant_log[0], 0);
      check("tie_order_1", grant_log[1], 1);
      check("tie_order_2", grant_log[2], 0);
      check("tie_order_3", grant_log[3], 1);
      for (int k = 1; k < 4; k++) check("tie_accept_gap", grant_cyc[k] - grant_cyc[k-1], 3);
    end

    // Divide must keep its operands on the ALU for all MULTI_CYC cycles.
    send('{1, 8'd20, 8'd6, 4'b1000, 8'd3, 4'b0000, MC}, ta, wa);
    for (int k = 0; k < MC; k++) begin
      @(negedge clk);
      check("hold_alu_a", 32'(alu_a), 20);
      check("hold_alu_b", 32'(alu_b), 6);
      check("hold_alu_ctrl", 32'(alu_ctrl), 32'h8);
      check("hold_no_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    end
    drain();

    for (int i = 0; i < 13; i++) begin
      send(tbl[i], ta, wa);
      check("vec_accept_wait", wa, 1);
      drain();
    end

    // Reset in the middle of a multiply aborts it without a response.
    send('{0, 8'd12, 8'd10, 4'b0010, 8'd120, 4'b0000, MC}, ta, wa);
    @(posedge clk);
    #2;
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd3; req0_ctrl = 4'b0000;
    check("abort_ready_while_busy", 32'(req0_ready), 0);
    rst_n = 1'b0;
    #1;
    check("abort_alu", 32'({alu_a, alu_b, alu_ctrl}), 0);
    check("abort_rsp", 32'({rsp_result, rsp_flags}), 0);
    check("abort_ready_busy", 32'({req0_ready, req1_ready, busy}), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send('{0, 8'd5, 8'd3, 4'b0000, 8'd8, 4'b0000, 1}, ta, wa);
    check("post_reset_accept_wait", wa, 1);
    drain();
    repeat (MC + 2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
